// File: rtl/reorder_buffer_pkg.sv
// Shared constants and type encodings for the reorder buffer, the register
// file and the dispatcher.
package reorder_buffer_pkg;

  // Reorder buffer index width; depth is 2**RoB_WIDTH.
  localparam int unsigned RoB_WIDTH = 3;

  // Extended register id: the MSB flags "no architectural destination".
  localparam int unsigned EX_REG_WIDTH = 6;
  localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000;

  // Dependency tag meaning "operand has no pending producer" (one bit wider
  // than a buffer index so it can never alias a real entry).
  localparam logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

  // Instruction class held in each entry.
  typedef enum logic [1:0] {
    ROB_REG    = 2'b00,
    ROB_BRANCH = 2'b01,
    ROB_STORE  = 2'b10,
    ROB_NONE   = 2'b11
  } rob_type_e;

  // A branch is mispredicted when its resolved direction differs from the
  // direction fetch assumed.
  function automatic logic is_mispredict(input rob_type_e kind,
                                         input logic      pred_taken,
                                         input logic      taken);
    return (kind == ROB_BRANCH) && (pred_taken != taken);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular buffer of in-flight instructions that accepts one
// dispatch and one CDB result per cycle and commits in program order from the
// head. A mispredicted branch at commit redirects fetch and flushes the buffer.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned              RoB_WIDTH    = reorder_buffer_pkg::RoB_WIDTH,
  parameter int unsigned              EX_REG_WIDTH = reorder_buffer_pkg::EX_REG_WIDTH,
  parameter logic [EX_REG_WIDTH-1:0]  NON_REG      = reorder_buffer_pkg::NON_REG
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,

  // Dispatch
  input  logic                    DPRoB_en,
  input  logic [1:0]              DPRoB_type,
  input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
  input  logic                    DPRoB_pred_taken,
  input  logic                    DPRoB_ready,
  input  logic [31:0]             DPRoB_value,
  input  logic [RoB_WIDTH-1:0]    DPRoB_Qj_index,
  input  logic [RoB_WIDTH-1:0]    DPRoB_Qk_index,
  output logic                    RoBDP_full,
  output logic [RoB_WIDTH-1:0]    RoBDP_index,
  output logic                    RoBDP_Qj_ready,
  output logic [31:0]             RoBDP_Vj,
  output logic                    RoBDP_Qk_ready,
  output logic [31:0]             RoBDP_Vk,

  // Common data bus
  input  logic                    CDB_en,
  input  logic [RoB_WIDTH-1:0]    CDB_RoB_index,
  input  logic [31:0]             CDB_value,
  input  logic                    CDB_taken,

  // Commit to register file
  output logic                    RoBRF_en,
  output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  output logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  output logic [31:0]             RoBRF_value,
  output logic                    RoBRF_pre_judge,

  // Fetch redirect
  output logic                    RoBIF_jump_en,
  output logic [31:0]             RoBIF_pc,

  // Store release to the load/store buffer
  output logic                    RoBLSB_store_commit,
  output logic [RoB_WIDTH-1:0]    RoBLSB_RoB_index
);

  localparam int unsigned            RoB_SIZE   = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH:0]     FULL_COUNT = {1'b1, {RoB_WIDTH{1'b0}}};
  localparam logic [RoB_WIDTH:0]     CNT_ONE    = (RoB_WIDTH + 1)'(1);
  localparam logic [RoB_WIDTH-1:0]   IDX_ONE    = RoB_WIDTH'(1);

  // Entry storage, one array per field.
  logic                    busy_q       [RoB_SIZE];
  logic                    ready_q      [RoB_SIZE];
  rob_type_e               type_q       [RoB_SIZE];
  logic [EX_REG_WIDTH-1:0] rd_q         [RoB_SIZE];
  logic [31:0]             value_q      [RoB_SIZE];
  logic                    pred_taken_q [RoB_SIZE];
  logic                    taken_q      [RoB_SIZE];

  logic [RoB_WIDTH-1:0]    head;
  logic [RoB_WIDTH-1:0]    tail;
  logic [RoB_WIDTH:0]      count;

  logic                    full;
  logic                    commit;
  logic                    mispredict;
  logic                    dispatch;
  logic                    cdb_hit;

  // Per-cycle control decisions, all taken from the pre-edge state.
  always_comb begin
    full       = (count == FULL_COUNT);
    commit     = Sys_rdy && !Sys_rst && busy_q[head] && ready_q[head];
    mispredict = commit && is_mispredict(type_q[head], pred_taken_q[head],
                                         taken_q[head]);
    dispatch   = Sys_rdy && DPRoB_en && !full;
    cdb_hit    = Sys_rdy && CDB_en && busy_q[CDB_RoB_index];
  end

  // Dispatch handshake: the tail is the index handed to the incoming entry.
  always_comb begin
    RoBDP_full  = full;
    RoBDP_index = tail;
  end

  // Operand lookup with CDB bypass; a not-yet-ready entry reads as zero.
  always_comb begin
    RoBDP_Qj_ready = 1'b0;
    RoBDP_Vj       = '0;
    RoBDP_Qk_ready = 1'b0;
    RoBDP_Vk       = '0;
    if (CDB_en && (CDB_RoB_index == DPRoB_Qj_index)) begin
      RoBDP_Qj_ready = 1'b1;
      RoBDP_Vj       = CDB_value;
    end else if (ready_q[DPRoB_Qj_index]) begin
      RoBDP_Qj_ready = 1'b1;
      RoBDP_Vj       = value_q[DPRoB_Qj_index];
    end
    if (CDB_en && (CDB_RoB_index == DPRoB_Qk_index)) begin
      RoBDP_Qk_ready = 1'b1;
      RoBDP_Vk       = CDB_value;
    end else if (ready_q[DPRoB_Qk_index]) begin
      RoBDP_Qk_ready = 1'b1;
      RoBDP_Vk       = value_q[DPRoB_Qk_index];
    end
  end

  // Commit port decode from the head entry.
  always_comb begin
    RoBRF_en            = commit;
    RoBRF_RoB_index     = head;
    RoBRF_rd            = NON_REG;
    RoBRF_value         = value_q[head];
    RoBRF_pre_judge     = !mispredict;
    RoBIF_jump_en       = mispredict;
    RoBIF_pc            = '0;
    RoBLSB_store_commit = 1'b0;
    RoBLSB_RoB_index    = head;
    if (commit) begin
      unique case (type_q[head])
        ROB_BRANCH: RoBRF_rd = NON_REG;
        ROB_STORE: begin
          RoBRF_rd            = NON_REG;
          RoBLSB_store_commit = 1'b1;
        end
        default:    RoBRF_rd = rd_q[head];
      endcase
    end
    if (mispredict) begin
      RoBIF_pc = value_q[head];
    end
  end

  // Buffer state update: reset and mispredict flush share the clear path.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst || mispredict) begin
      for (int unsigned i = 0; i < RoB_SIZE; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (Sys_rdy) begin
      // CDB write first so a same-cycle commit of that entry clears it last.
      if (cdb_hit) begin
        ready_q[CDB_RoB_index] <= 1'b1;
        value_q[CDB_RoB_index] <= CDB_value;
        taken_q[CDB_RoB_index] <= CDB_taken;
      end
      if (commit) begin
        busy_q[head]  <= 1'b0;
        ready_q[head] <= 1'b0;
        head          <= head + IDX_ONE;
      end
      if (dispatch) begin
        busy_q[tail]       <= 1'b1;
        ready_q[tail]      <= DPRoB_ready;
        type_q[tail]       <= rob_type_e'(DPRoB_type);
        rd_q[tail]         <= DPRoB_rd;
        value_q[tail]      <= DPRoB_value;
        pred_taken_q[tail] <= DPRoB_pred_taken;
        taken_q[tail]      <= 1'b0;
        tail               <= tail + IDX_ONE;
      end
      unique case ({dispatch, commit})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by
// random traffic, all checked against a queue-based program-order model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy;
  logic        dp_en, dp_pred, dp_ready;
  logic [1:0]  dp_type;
  logic [5:0]  dp_rd;
  logic [31:0] dp_value;
  logic [2:0]  qj_idx, qk_idx;
  logic        full;
  logic [2:0]  dp_index;
  logic        qj_ready, qk_ready;
  logic [31:0] vj, vk;
  logic        cdb_en, cdb_taken;
  logic [2:0]  cdb_idx;
  logic [31:0] cdb_val;
  logic        rf_en, pre_judge, jump_en, st_commit;
  logic [2:0]  rf_idx, lsb_idx;
  logic [5:0]  rf_rd;
  logic [31:0] rf_val, pc;

  reorder_buffer #(
    .RoB_WIDTH   (3),
    .EX_REG_WIDTH(6),
    .NON_REG     (6'b100000)
  ) dut (
    .Sys_clk            (clk),
    .Sys_rst            (rst),
    .Sys_rdy            (rdy),
    .DPRoB_en           (dp_en),
    .DPRoB_type         (dp_type),
    .DPRoB_rd           (dp_rd),
    .DPRoB_pred_taken   (dp_pred),
    .DPRoB_ready        (dp_ready),
    .DPRoB_value        (dp_value),
    .DPRoB_Qj_index     (qj_idx),
    .DPRoB_Qk_index     (qk_idx),
    .RoBDP_full         (full),
    .RoBDP_index        (dp_index),
    .RoBDP_Qj_ready     (qj_ready),
    .RoBDP_Vj           (vj),
    .RoBDP_Qk_ready     (qk_ready),
    .RoBDP_Vk           (vk),
    .CDB_en             (cdb_en),
    .CDB_RoB_index      (cdb_idx),
    .CDB_value          (cdb_val),
    .CDB_taken          (cdb_taken),
    .RoBRF_en           (rf_en),
    .RoBRF_RoB_index    (rf_idx),
    .RoBRF_rd           (rf_rd),
    .RoBRF_value        (rf_val),
    .RoBRF_pre_judge    (pre_judge),
    .RoBIF_jump_en      (jump_en),
    .RoBIF_pc           (pc),
    .RoBLSB_store_commit(st_commit),
    .RoBLSB_RoB_index   (lsb_idx)
  );

  // Program-order model: front of the queue is the oldest instruction.
  typedef struct {
    bit [2:0]  idx;
    bit        ready;
    bit [1:0]  typ;
    bit [5:0]  rd;
    bit [31:0] value;
    bit        pred;
    bit        taken;
  } ent_t;

  ent_t     q[$];
  bit [2:0] m_tail;
  int       n_cmp  = 0;
  int       n_fail = 0;
  bit       check_en;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [2:0] qi, output bit r,
                        output logic [31:0] v);
    r = 1'b0;
    v = '0;
    if (cdb_en && cdb_idx == qi) begin
      r = 1'b1;
      v = cdb_val;
    end else begin
      foreach (q[k]) begin
        if (q[k].idx == qi && q[k].ready) begin
          r = 1'b1;
          v = q[k].value;
        end
      end
    end
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1;
    dp_en = 1'b0; dp_type = 2'b00; dp_rd = '0; dp_pred = 1'b0;
    dp_ready = 1'b0; dp_value = '0; qj_idx = '0; qk_idx = '0;
    cdb_en = 1'b0; cdb_idx = '0; cdb_val = '0; cdb_taken = 1'b0;
  endtask

  // Check outputs for the current inputs, advance the model, clock once.
  task automatic cycle();
    bit          commit, mis, was_full, r;
    ent_t        h;
    bit [2:0]    head;
    logic [31:0] v;
    #1;
    was_full = (q.size() == 8);
    commit   = 1'b0;
    h        = '{default: '0};
    if (q.size() > 0) begin
      h      = q[0];
      commit = rdy && !rst && h.ready;
    end
    head = m_tail - 3'(q.size());
    mis  = commit && h.typ == 2'b01 && h.taken != h.pred;
    if (check_en) begin
      check("full", 32'(full), 32'(was_full));
      check("dp_index", 32'(dp_index), 32'(m_tail));
      check("rf_en", 32'(rf_en), 32'(commit));
      check("pre_judge", 32'(pre_judge), 32'(!mis));
      check("jump_en", 32'(jump_en), 32'(mis));
      check("store_commit", 32'(st_commit), 32'(commit && h.typ == 2'b10));
      if (commit) begin
        check("rf_index", 32'(rf_idx), 32'(head));
        check("rf_rd", 32'(rf_rd), 32'(h.typ == 2'b00 ? h.rd : NON_REG));
        check("rf_value", rf_val, h.value);
      end
      if (mis) check("jump_pc", pc, h.value);
      if (commit && h.typ == 2'b10) check("lsb_index", 32'(lsb_idx), 32'(head));
      lookup(qj_idx, r, v);
      check("qj_ready", 32'(qj_ready), 32'(r));
      check("vj", vj, v);
      lookup(qk_idx, r, v);
      check("qk_ready", 32'(qk_ready), 32'(r));
      check("vk", vk, v);
    end
    if (rst) begin
      q.delete();
      m_tail = '0;
    end else if (rdy) begin
      if (mis) begin
        q.delete();
        m_tail = '0;
      end else begin
        if (cdb_en) begin
          foreach (q[k]) begin
            if (q[k].idx == cdb_idx) begin
              q[k].ready = 1'b1;
              q[k].value = cdb_val;
              q[k].taken = cdb_taken;
            end
          end
        end
        if (commit) void'(q.pop_front());
        if (dp_en && !was_full) begin
          q.push_back('{m_tail, dp_ready, dp_type, dp_rd, dp_value, dp_pred, 1'b0});
          m_tail = m_tail + 3'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned t;
    idle();
    q.delete();
    m_tail = '0;

    // Initial reset; outputs are undefined before it takes effect.
    check_en = 1'b0;
    rst = 1'b1;
    cycle();
    check_en = 1'b1;
    idle();
    check("reset_full", 32'(full), 32'd0);
    check("reset_index", 32'(dp_index), 32'd0);
    cycle();

    // Fill with eight not-ready reg-writes; tail wraps 7 -> 0.
    for (int i = 0; i < 8; i++) begin
      idle();
      dp_en = 1'b1; dp_rd = 6'(i + 1); dp_value = 32'hdead0000 + 32'(i);
      cycle();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_tail", 32'(dp_index), 32'd0);

    // Ninth dispatch is ignored.
    idle(); dp_en = 1'b1; dp_rd = 6'd9;
    cycle();
    check("ninth_tail", 32'(dp_index), 32'd0);

    // Out-of-order completion: index 2 first, head stays blocked.
    idle(); cdb_en = 1'b1; cdb_idx = 3'd2; cdb_val = 32'h55;
    cycle();
    idle();
    cycle();
    check("blocked_no_commit", 32'(rf_en), 32'd0);
    idle(); cdb_en = 1'b1; cdb_idx = 3'd0; cdb_val = 32'h100;
    cycle();

    // Head ready while full: same-cycle dispatch refused, count drops to 7.
    idle(); dp_en = 1'b1; dp_rd = 6'd10;
    cycle();
    check("refused_tail", 32'(dp_index), 32'd0);
    check("refused_full", 32'(full), 32'd0);
    idle();
    cycle();
    idle(); cdb_en = 1'b1; cdb_idx = 3'd1; cdb_val = 32'h11;
    cycle();
    idle();
    cycle();
    check("idx2_commit", 32'(rf_en), 32'd1);
    check("idx2_index", 32'(rf_idx), 32'd2);
    check("idx2_value", rf_val, 32'h55);
    for (int i = 3; i < 8; i++) begin
      idle(); cdb_en = 1'b1; cdb_idx = 3'(i); cdb_val = 32'h200 + 32'(i);
      cycle();
    end
    idle(); cycle();
    idle(); cycle();

    // Mispredicted branch at head redirects and flushes.
    idle(); rst = 1'b1; cycle();
    idle(); dp_en = 1'b1; dp_type = 2'b01; dp_pred = 1'b0; cycle();
    idle(); dp_en = 1'b1; dp_rd = 6'd4; cycle();
    idle(); cdb_en = 1'b1; cdb_idx = 3'd0; cdb_val = 32'h1000; cdb_taken = 1'b1;
    cycle();
    idle(); dp_en = 1'b1; dp_rd = 6'd5; cdb_en = 1'b1; cdb_idx = 3'd1; cdb_val = 32'h9;
    #1;
    check("mis_pre_judge", 32'(pre_judge), 32'd0);
    check("mis_jump_en", 32'(jump_en), 32'd1);
    check("mis_pc", pc, 32'h1000);
    cycle();
    check("flush_index", 32'(dp_index), 32'd0);
    check("flush_full", 32'(full), 32'd0);
    check("flush_jump_off", 32'(jump_en), 32'd0);
    idle(); cycle();

    // Operand lookup bypasses the CDB.
    for (int i = 0; i < 4; i++) begin
      idle(); dp_en = 1'b1; dp_rd = 6'(i); cycle();
    end
    idle(); qj_idx = 3'd3; cdb_en = 1'b1; cdb_idx = 3'd3; cdb_val = 32'hABCD;
    #1;
    check("bypass_ready", 32'(qj_ready), 32'd1);
    check("bypass_value", vj, 32'hABCD);
    cycle();

    // Sys_rdy low freezes everything, including a ready head.
    idle(); cdb_en = 1'b1; cdb_idx = 3'd0; cdb_val = 32'h7; cycle();
    idle(); rdy = 1'b0; dp_en = 1'b1; cdb_en = 1'b1; cdb_idx = 3'd1;
    #1;
    check("frozen_no_commit", 32'(rf_en), 32'd0);
    cycle();
    check("frozen_tail", 32'(dp_index), 32'd4);

    // Mid-stream reset discards a ready head without committing it.
    idle(); rst = 1'b1;
    #1;
    check("rst_no_commit", 32'(rf_en), 32'd0);
    cycle();
    check("rst_full", 32'(full), 32'd0);
    check("rst_index", 32'(dp_index), 32'd0);
    idle(); cycle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      rst      = ($urandom_range(99) == 0);
      rdy      = ($urandom_range(9) != 0);
      dp_en    = ($urandom_range(9) < 6);
      t        = $urandom_range(99);
      dp_type  = (t < 70) ? 2'b00 : (t < 85) ? 2'b01 : 2'b10;
      dp_rd    = 6'($urandom_range(32));
      dp_pred  = 1'($urandom);
      dp_ready = ($urandom_range(3) == 0);
      dp_value = $urandom;
      qj_idx   = 3'($urandom_range(7));
      qk_idx   = 3'($urandom_range(7));
      cdb_en   = ($urandom_range(9) < 6);
      if (q.size() > 0 && $urandom_range(3) != 0)
        cdb_idx = q[$urandom_range(q.size() - 1)].idx;
      else
        cdb_idx = 3'($urandom_range(7));
      cdb_val   = $urandom;
      cdb_taken = 1'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters SHALL be: RoB_WIDTH, 3, index width (depth 2^RoB_WIDTH = RoB_SIZE); EX_REG_WIDTH, 6, extended register id; NON_REG, 6'b100000, "no destination".
REQ-002 Sys_clk  in  1  single clock; all state on posedge.
REQ-003 Sys_rst  in  1  synchronous, active-high reset.
REQ-004 Sys_rdy  in  1  global enable; when 0, no state change and no commit.
REQ-005 DPRoB_en  in  1  allocate one entry this cycle.
REQ-006 DPRoB_type  in  2  00 reg-write, 01 branch, 10 store; 11 never dispatched.
REQ-007 DPRoB_rd  in  EX_REG_WIDTH  destination, or NON_REG.
REQ-008 DPRoB_pred_taken  in  1  predicted direction (branch only).
REQ-009 DPRoB_ready, DPRoB_value  in  1, 32  result already known at dispatch (e.g. LUI).
REQ-010 DPRoB_Qj_index, DPRoB_Qk_index  in  RoB_WIDTH  operand lookup indices.
REQ-011 RoBDP_full  out  1  count == RoB_SIZE.
REQ-012 RoBDP_index  out  RoB_WIDTH  tail index assigned to the current dispatch.
REQ-013 RoBDP_Qj_ready/RoBDP_Vj, RoBDP_Qk_ready/RoBDP_Vk  out  1/32  operand lookup result.
REQ-014 CDB_en, CDB_RoB_index, CDB_value, CDB_taken  in  1, RoB_WIDTH, 32, 1  execution result; for a branch, value = correct next PC.
REQ-015 RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value  out  1, RoB_WIDTH, EX_REG_WIDTH, 32  commit port.
REQ-016 RoBRF_pre_judge  out  1  0 only during the commit cycle of a mispredicted branch.
REQ-017 RoBIF_jump_en, RoBIF_pc  out  1, 32  redirect fetch on mispredict.
REQ-018 RoBLSB_store_commit, RoBLSB_RoB_index  out  1, RoB_WIDTH  release the head store.

Function
REQ-019 Storage SHALL be a circular buffer of RoB_SIZE entries {busy, ready, type, rd, value, pred_taken, taken}, with head, tail, and count (RoB_WIDTH+1 bits).
REQ-020 Dispatch with DPRoB_en=1 and not full SHALL write the entry at tail (busy=1, ready=DPRoB_ready) and advance tail modulo RoB_SIZE; RoBDP_index = tail, combinationally.
REQ-021 DPRoB_en while full SHALL be ignored.
REQ-022 CDB_en SHALL set ready=1 and store value/taken in the busy entry at CDB_RoB_index; a CDB write to a non-busy entry SHALL be ignored.
REQ-023 Commit SHALL be combinational from the head: commit = Sys_rdy && head busy && head ready; no added latency.
REQ-024 Reg-write commit SHALL assert RoBRF_en with head index, rd, value; branch and store commits SHALL drive RoBRF_en=1 with rd=NON_REG.
REQ-025 Store commit SHALL pulse RoBLSB_store_commit for one cycle.
REQ-026 Branch commit with taken != pred_taken SHALL drive RoBRF_pre_judge=0, RoBIF_jump_en=1, RoBIF_pc=value; at that posedge all entries SHALL clear and head=tail=count=0, ignoring same-cycle dispatch and CDB.
REQ-027 Simultaneous dispatch and commit SHALL leave count unchanged; dispatch into a full buffer in the same cycle as a commit SHALL be refused (full is evaluated before commit).
REQ-028 Lookup: Qx_ready=1 if the entry is ready, or if CDB_en and CDB_RoB_index match (bypass, V=CDB_value); otherwise V=entry value and ready=0 yields V=0.
REQ-029 A commit and a CDB write to the head entry in the same cycle SHALL commit only if the entry was already ready (no CDB-to-commit bypass).
REQ-030 Idle outputs SHALL be RoBRF_en=0, RoBRF_pre_judge=1, RoBIF_jump_en=0, RoBLSB_store_commit=0.

Reset
REQ-031 Sys_rst SHALL clear all busy bits and set head=tail=count=0, with priority over Sys_rdy and all inputs.
REQ-032 After reset, outputs SHALL equal the REQ-030 idle values, RoBDP_full=0, and RoBDP_index=0; a reset mid-operation SHALL discard all entries with no commit.

Structure
REQ-033 The shared package SHALL hold RoB_WIDTH, EX_REG_WIDTH, NON_REG, NON_DEP and the type encodings, and these SHALL also be used by the register file and dispatcher.
REQ-034 The block SHALL be a single module with no sub-module; the entry array SHALL be inferred registers.

Verification
REQ-035 Dispatch 8 reg-writes with ready=0 -> RoBDP_full=1 on the 8th; a 9th DPRoB_en is ignored and tail stays 0.
REQ-036 CDB to index 2 with value 0x55, then index 0 -> no commit until index 0 is ready; then indices 0, 1 (once ready), 2 commit in order with RoBRF_value 0x55 at index 2.
REQ-037 Branch pred_taken=0, CDB_taken=1, value 0x1000 at head -> pre_judge=0, jump_en=1, pc=0x1000 for one cycle; count=0 next cycle.
REQ-038 Lookup of index 3 in the cycle CDB writes index 3 with 0xABCD -> Qj_ready=1, Vj=0xABCD.
REQ-039 Full buffer with commit and dispatch in the same cycle -> dispatch refused and count=7; tail wrap from 7 to 0 verified.
REQ-040 Assert Sys_rst mid-stream -> no RoBRF_en and full=0 next cycle; Sys_rdy=0 -> state frozen.
